dw_tile_sequencer: RTL
======================

# dw_tile_sequencer

Control FSM for the depthwise data router. It walks one feature-map tile in row groups, column blocks and kernel rows. For each step it drives the line-buffer read address (rpsel/bank/row/col), the reg-array command, the inter-row FIFO pop and the DW PE enable. It sits between the tile-level layer controller (start/config/done) and the data router datapath, and replaces hand-driven sequencing of the router.

## Interface
- KSIZE, 3, kernel width/height; legal 1..3
- POY, 3, output rows per row group (reg arrays in router)
- POX, 16, output columns per column block
- BUFW, 32, buffer words per read
- STRIDE, 1, conv stride; legal 1..2
- CNTW, 8, width of tile-size config fields

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_rowgrp  in  CNTW  row groups in tile; latched on accepted start
- cfg_colblk  in  CNTW  column blocks per row group; latched on accepted start
- pe_ready  in  1  DW PE array can accept a beat; low = stall
- busy  out  1  high from cycle after accepted start through DONE cycle
- done  out  1  one-cycle pulse at end of tile
- rpsel  out  2  line-buffer rotation select, 0..2
- bank  out  2  buffer bank for mux, (rpsel + ky) mod 3
- row  out  2  current kernel row ky
- col  out  29  buffer column address
- reg_array_cmd  out  2  00 HOLD, 01 LOAD, 10 SHIFT, 11 CLEAR
- fifo_read  out  1  pop inter-row FIFOs
- dwpe_ena  out  1  PE accumulate enable
- blkend  out  1  one-cycle pulse on last beat of a column block

## Operation
- States: IDLE, CLR, LOAD, SHIFT, DONE. Counters: rg (row group), cb (column block), ky (kernel row), kx (shift index 0..KSIZE-1).
- IDLE: all outputs 0. start=1 latches cfg, zeroes counters and rpsel, and goes to CLR. start outside IDLE is ignored.
- CLR: one cycle with cmd=CLEAR. Goes to LOAD. If the latched cfg_rowgrp==0 or cfg_colblk==0, goes to DONE instead.
- LOAD: one beat with cmd=LOAD, col = cb*POX*STRIDE, row=ky, bank=(rpsel+ky) mod 3. fifo_read=1 iff ky>0. dwpe_ena=0. Goes to SHIFT with kx=0.
- SHIFT: KSIZE beats with cmd=SHIFT and dwpe_ena=1; col is held.
  - After kx==KSIZE-1: if ky<KSIZE-1, ky++ and go to LOAD.
  - Otherwise ky=0 and blkend is pulsed on that last SHIFT beat.
  - Then cb++ and go to LOAD. If cb was the last block: cb=0, rg++, rpsel=(rpsel+1) mod 3, then LOAD.
  - If rg was also the last group, go to DONE.
- DONE: one cycle with done=1 and busy=1, cmd=HOLD. Then IDLE.
- Stall: in LOAD/SHIFT with pe_ready=0, the beat is not issued.
  - cmd=HOLD, dwpe_ena=0, fifo_read=0, blkend=0.
  - Addresses hold their last value. Counters and state are frozen.
  - The beat issues on the first cycle pe_ready=1.
  - CLR and DONE ignore pe_ready.
- col arithmetic: 29-bit unsigned, zero-extended product. Overflow cannot occur for CNTW<=8.
- Counter wrap: rg and cb compare against the latched cfg minus 1. There is no wrap beyond the cfg values.

## Timing
- All outputs are registered and reflect the state entered at the same edge.
- Cycle 0 = edge sampling start. Cycle 1 = CLR (busy=1, cmd=CLEAR). Cycle 2 = first LOAD.
- Each column block takes KSIZE*(1+KSIZE) unstalled beats (12 for KSIZE=3).
- Unstalled tile: done is at cycle 2 + cfg_rowgrp*cfg_colblk*KSIZE*(1+KSIZE). busy falls the cycle after done.
- Each stall cycle adds exactly one cycle to that total.
- Reset: rst=1 at any edge, including mid-tile, forces IDLE on that edge.
  - All outputs are 0 after the edge, counters are cleared and the latched cfg is discarded.
  - A start coincident with rst is dropped.
- Back-to-back tiles: start asserted on the cycle after done, while in IDLE, is accepted. There is no dead cycle beyond IDLE.

## Test plan
- Minimal tile: KSIZE=3, start with cfg_rowgrp=1, cfg_colblk=1, pe_ready=1.
  - Expect CLR at cycle 1, then LOAD/SHIFT/SHIFT/SHIFT x3 with row=0,1,2.
  - Expect fifo_read only on LOADs 2 and 3, blkend at cycle 13, done at cycle 14, col=0 throughout.
- Multi-block: cfg_rowgrp=2, cfg_colblk=3.
  - Expect col sequence 0,16,32 per group.
  - Expect rpsel=0 in group 0 and 1 in group 1, bank=(rpsel+ky) mod 3.
  - Expect 6 blkend pulses and done at cycle 74.
- Stall: pe_ready=0 for cycles 5-7 of the minimal tile.
  - Expect cmd=HOLD, dwpe_ena=0 and addresses frozen during the stall.
  - Expect the beat sequence to resume unchanged and done at cycle 17.
- Zero config: cfg_colblk=0 -> CLR at cycle 1, done at cycle 2, no LOAD/SHIFT/fifo_read/dwpe_ena ever asserted.
- Reset mid-tile: rst=1 at cycle 8 of a 2x3 tile.
  - Expect all outputs 0 and busy=0 at cycle 9.
  - A new start at cycle 10 produces CLR at cycle 11 with fresh cfg.
- Start while busy: extra start pulses at cycles 3 and 14 of the minimal tile are ignored. Only one done is produced.

Source files
------------

// File: rtl/dw_tile_sequencer.sv
// Depthwise router sequencer: walks a tile in row groups, column blocks and kernel rows,
// issuing line-buffer addresses, reg-array commands, FIFO pops and PE enables per beat.
module dw_tile_sequencer #(
    parameter int KSIZE  = 3,
    parameter int POY    = 3,
    parameter int POX    = 16,
    parameter int BUFW   = 32,
    parameter int STRIDE = 1,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] cfg_rowgrp,
    input  logic [CNTW-1:0] cfg_colblk,
    input  logic            pe_ready,
    output logic            busy,
    output logic            done,
    output logic [1:0]      rpsel,
    output logic [1:0]      bank,
    output logic [1:0]      row,
    output logic [28:0]     col,
    output logic [1:0]      reg_array_cmd,
    output logic            fifo_read,
    output logic            dwpe_ena,
    output logic            blkend
);

    if (KSIZE < 1 || KSIZE > 3 || STRIDE < 1 || STRIDE > 2 || POY < 1 || BUFW < 1 || POX < 1
        || CNTW < 1 || CNTW > 8) begin : g_bad_param
        $error("dw_tile_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0]  CMD_HOLD  = 2'b00;
    localparam logic [1:0]  CMD_LOAD  = 2'b01;
    localparam logic [1:0]  CMD_SHIFT = 2'b10;
    localparam logic [1:0]  CMD_CLEAR = 2'b11;
    localparam logic [1:0]  KLAST     = 2'(KSIZE - 1);
    localparam logic [28:0] COL_STEP  = 29'(POX * STRIDE);

    function automatic logic [1:0] bank_of(input logic [1:0] rp, input logic [1:0] ky);
        logic [2:0] s;
        s = {1'b0, rp} + {1'b0, ky};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    function automatic logic [28:0] col_of(input logic [CNTW-1:0] cb);
        return 29'(cb) * COL_STEP;
    endfunction

    state_t          state_q, state_d;
    logic [CNTW-1:0] cfg_rg_q, cfg_rg_d, cfg_cb_q, cfg_cb_d;
    logic [CNTW-1:0] rg_q, rg_d, cb_q, cb_d;
    logic [1:0]      ky_q, ky_d, kx_q, kx_d, rps_q, rps_d;
    // beat_q: the LOAD/SHIFT beat of state_q was actually issued (not stalled) this cycle
    logic            beat_q, beat_d;

    logic            busy_q, busy_d, done_q, done_d;
    logic [1:0]      cmd_q, cmd_d;
    logic            fifo_q, fifo_d, ena_q, ena_d, blk_q, blk_d;
    logic [1:0]      rpsel_q, rpsel_d, bank_q, bank_d, row_q, row_d;
    logic [28:0]     col_q, col_d;
    logic            issue;

    always_comb begin
        state_d  = state_q;
        cfg_rg_d = cfg_rg_q;
        cfg_cb_d = cfg_cb_q;
        rg_d     = rg_q;
        cb_d     = cb_q;
        ky_d     = ky_q;
        kx_d     = kx_q;
        rps_d    = rps_q;
        beat_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_rg_d = cfg_rowgrp;
                    cfg_cb_d = cfg_colblk;
                    rg_d     = '0;
                    cb_d     = '0;
                    ky_d     = '0;
                    kx_d     = '0;
                    rps_d    = '0;
                    state_d  = S_CLR;
                end
            end
            S_CLR: begin
                if (cfg_rg_q == '0 || cfg_cb_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    beat_d  = pe_ready;
                end
            end
            S_LOAD: begin
                if (!beat_q) begin
                    beat_d = pe_ready;
                end else begin
                    state_d = S_SHIFT;
                    kx_d    = '0;
                    beat_d  = pe_ready;
                end
            end
            S_SHIFT: begin
                if (!beat_q) begin
                    beat_d = pe_ready;
                end else if (kx_q != KLAST) begin
                    kx_d   = kx_q + 2'd1;
                    beat_d = pe_ready;
                end else if (ky_q != KLAST) begin
                    ky_d    = ky_q + 2'd1;
                    state_d = S_LOAD;
                    beat_d  = pe_ready;
                end else begin
                    ky_d    = '0;
                    state_d = S_LOAD;
                    beat_d  = pe_ready;
                    if (cb_q == cfg_cb_q - CNTW'(1)) begin
                        cb_d = '0;
                        if (rg_q == cfg_rg_q - CNTW'(1)) begin
                            state_d = S_DONE;
                            beat_d  = 1'b0;
                        end else begin
                            rg_d  = rg_q + CNTW'(1);
                            rps_d = (rps_q == 2'd2) ? 2'd0 : rps_q + 2'd1;
                        end
                    end else begin
                        cb_d = cb_q + CNTW'(1);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the state being entered at this edge
    always_comb begin
        issue   = (state_d == S_LOAD || state_d == S_SHIFT) && beat_d;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        cmd_d   = CMD_HOLD;
        if (state_d == S_CLR) cmd_d = CMD_CLEAR;
        else if (issue && state_d == S_LOAD) cmd_d = CMD_LOAD;
        else if (issue) cmd_d = CMD_SHIFT;
        fifo_d  = issue && (state_d == S_LOAD) && (ky_d != 2'd0);
        ena_d   = issue && (state_d == S_SHIFT);
        blk_d   = ena_d && (kx_d == KLAST) && (ky_d == KLAST);
        rpsel_d = rpsel_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        if (state_d == S_IDLE) begin
            rpsel_d = '0;
            bank_d  = '0;
            row_d   = '0;
            col_d   = '0;
        end else if (issue) begin
            rpsel_d = rps_d;
            bank_d  = bank_of(rps_d, ky_d);
            row_d   = ky_d;
            col_d   = col_of(cb_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cfg_rg_q <= '0;
            cfg_cb_q <= '0;
            rg_q     <= '0;
            cb_q     <= '0;
            ky_q     <= '0;
            kx_q     <= '0;
            rps_q    <= '0;
            beat_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cmd_q    <= CMD_HOLD;
            fifo_q   <= 1'b0;
            ena_q    <= 1'b0;
            blk_q    <= 1'b0;
            rpsel_q  <= '0;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            state_q  <= state_d;
            cfg_rg_q <= cfg_rg_d;
            cfg_cb_q <= cfg_cb_d;
            rg_q     <= rg_d;
            cb_q     <= cb_d;
            ky_q     <= ky_d;
            kx_q     <= kx_d;
            rps_q    <= rps_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cmd_q    <= cmd_d;
            fifo_q   <= fifo_d;
            ena_q    <= ena_d;
            blk_q    <= blk_d;
            rpsel_q  <= rpsel_d;
            bank_q   <= bank_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign rpsel         = rpsel_q;
    assign bank          = bank_q;
    assign row           = row_q;
    assign col           = col_q;
    assign reg_array_cmd = cmd_q;
    assign fifo_read     = fifo_q;
    assign dwpe_ena      = ena_q;
    assign blkend        = blk_q;

endmodule
